// File: rtl/pipeline_stage_sequencer_pkg.sv
// Shared definitions for the pipeline stage sequencer: FSM state encoding,
// run-time mode constants and a stage-index range helper.
package pipeline_stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_SEQ   = 2'd1,
        ST_PIPE  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    localparam logic MODE_SEQUENTIAL = 1'b0;
    localparam logic MODE_PIPELINED  = 1'b1;

    // True when a stage index names a real stage.
    function automatic logic stage_in_range(input logic [31:0] idx, input int unsigned stages);
        return idx < stages;
    endfunction

endpackage

// File: rtl/pipeline_stage_sequencer_if.sv
// Control bundle between the stage sequencer and the CPU datapath.
//   mode, stall_req/stall_stage, flush_req/flush_stage : datapath -> sequencer
//   flush_ack, pc_wren, stage_wren, stage_bubble,
//   ram_wren, reg_wren, retire                        : sequencer -> datapath
// master = sequencer side, slave = datapath side.
interface pipeline_stage_sequencer_if #(
    parameter int unsigned STAGES = 5,
    parameter int unsigned SW     = $clog2(STAGES)
);
    logic              mode;
    logic              stall_req;
    logic [SW-1:0]     stall_stage;
    logic              flush_req;
    logic [SW-1:0]     flush_stage;
    logic              flush_ack;
    logic              pc_wren;
    logic [STAGES-2:0] stage_wren;
    logic [STAGES-2:0] stage_bubble;
    logic              ram_wren;
    logic              reg_wren;
    logic              retire;

    modport master (
        input  mode, stall_req, stall_stage, flush_req, flush_stage,
        output flush_ack, pc_wren, stage_wren, stage_bubble, ram_wren, reg_wren, retire
    );

    modport slave (
        output mode, stall_req, stall_stage, flush_req, flush_stage,
        input  flush_ack, pc_wren, stage_wren, stage_bubble, ram_wren, reg_wren, retire
    );
endinterface

// File: rtl/pipeline_stage_sequencer_hazard_mask_gen.sv
// Combinational stall/flush arbitration and per-pipeline-register masks.
//   stall_req/stall_stage : hazard stall request, stage k
//   flush_req/flush_stage : redirect request, stage f
//   flush_en              : flush may be accepted this cycle
//   stall_c / flush_c     : winning request after arbitration
//   hold_c[i]             : R[i] must not load (i < k)
//   bubble_c[i]           : R[i] loads a NOP (i == k on stall, i < f on flush)
module hazard_mask_gen
    import pipeline_stage_sequencer_pkg::*;
#(
    parameter int unsigned STAGES = 5,
    parameter int unsigned SW     = $clog2(STAGES)
) (
    input  logic              stall_req,
    input  logic [SW-1:0]     stall_stage,
    input  logic              flush_req,
    input  logic [SW-1:0]     flush_stage,
    input  logic              flush_en,
    output logic              stall_c,
    output logic              flush_c,
    output logic [STAGES-2:0] hold_c,
    output logic [STAGES-2:0] bubble_c
);
    localparam int unsigned RW = STAGES - 1;

    logic stall_ok;
    logic flush_ok;

    // Out-of-range indices count as no request; an older (deeper) flush squashes the stall.
    always_comb begin
        stall_ok = stall_req && stage_in_range(32'(stall_stage), STAGES);
        flush_ok = flush_en && flush_req && (flush_stage != '0)
                   && stage_in_range(32'(flush_stage), STAGES);
        flush_c  = flush_ok && (!stall_ok || (flush_stage >= stall_stage));
        stall_c  = stall_ok && !flush_c;
    end

    for (genvar g = 0; g < RW; g++) begin : g_mask
        assign hold_c[g]   = stall_c && (32'(g) < 32'(stall_stage));
        assign bubble_c[g] = (stall_c && (32'(g) == 32'(stall_stage)))
                           || (flush_c && (32'(g) < 32'(flush_stage)));
    end

endmodule

// File: rtl/pipeline_stage_sequencer.sv
// Stage sequencer for a STAGES-deep CPU: sequential (one stage per cycle) or
// pipelined (all stages per cycle with stall/flush), with a clean drain on
// the pipelined-to-sequential switch.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (master) : mode and hazard requests in; PC, pipeline-register,
//                  RAM/register-file commit enables and retire out.
// All outputs are combinational from state, token and requests.
module pipeline_stage_sequencer
    import pipeline_stage_sequencer_pkg::*;
#(
    parameter int unsigned STAGES    = 5,
    parameter int unsigned MEM_STAGE = 3,
    parameter int unsigned SW        = $clog2(STAGES)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    pipeline_stage_sequencer_if.master  bus
);
    localparam int unsigned RW = STAGES - 1;

    seq_state_e        state, state_nx;
    logic [STAGES-1:0] token, token_nx;
    logic [SW-1:0]     drain_cnt, drain_cnt_nx;
    logic              fresh, fresh_nx;

    logic              stall_c;
    logic              flush_c;
    logic [RW-1:0]     hold_c;
    logic [RW-1:0]     bubble_c;

    // Flushes are only accepted in PIPE; DRAIN reuses the stall masks.
    hazard_mask_gen #(
        .STAGES (STAGES),
        .SW     (SW)
    ) u_mask (
        .stall_req   (bus.stall_req),
        .stall_stage (bus.stall_stage),
        .flush_req   (bus.flush_req),
        .flush_stage (bus.flush_stage),
        .flush_en    (state == ST_PIPE),
        .stall_c     (stall_c),
        .flush_c     (flush_c),
        .hold_c      (hold_c),
        .bubble_c    (bubble_c)
    );

    // State, token, drain counter and first-PIPE flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_HOLD;
            token     <= STAGES'(1);
            drain_cnt <= '0;
            fresh     <= 1'b0;
        end else begin
            state     <= state_nx;
            token     <= token_nx;
            drain_cnt <= drain_cnt_nx;
            fresh     <= fresh_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx     = state;
        token_nx     = token;
        drain_cnt_nx = drain_cnt;
        fresh_nx     = 1'b0;
        unique case (state)
            ST_HOLD: begin
                token_nx = STAGES'(1);
                state_nx = (bus.mode == MODE_PIPELINED) ? ST_PIPE : ST_SEQ;
            end
            ST_SEQ: begin
                token_nx = {token[STAGES-2:0], token[STAGES-1]};
                // Mode is only honoured on the wrap so no instruction is cut short.
                if (token[STAGES-1] && (bus.mode == MODE_PIPELINED)) begin
                    state_nx = ST_PIPE;
                    fresh_nx = 1'b1;
                end
            end
            ST_PIPE: begin
                if (bus.mode == MODE_SEQUENTIAL) begin
                    state_nx     = ST_DRAIN;
                    drain_cnt_nx = SW'(STAGES - 1);
                end
            end
            ST_DRAIN: begin
                if (!stall_c) begin
                    if (drain_cnt <= SW'(1)) begin
                        state_nx     = ST_SEQ;
                        token_nx     = STAGES'(1);
                        drain_cnt_nx = '0;
                    end else begin
                        drain_cnt_nx = drain_cnt - SW'(1);
                    end
                end
            end
            default: state_nx = ST_HOLD;
        endcase
    end

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        bus.flush_ack    = 1'b0;
        bus.pc_wren      = 1'b0;
        bus.stage_wren   = '0;
        bus.stage_bubble = '0;
        bus.ram_wren     = 1'b0;
        bus.reg_wren     = 1'b0;
        bus.retire       = 1'b0;
        if (reset_n) begin
            unique case (state)
                ST_HOLD: begin
                    bus.stage_wren   = '1;
                    bus.stage_bubble = '1;
                end
                ST_SEQ: begin
                    bus.stage_wren = token[RW-1:0];
                    bus.ram_wren   = token[MEM_STAGE];
                    bus.reg_wren   = token[STAGES-1];
                    bus.pc_wren    = token[STAGES-1];
                    bus.retire     = token[STAGES-1];
                end
                ST_PIPE, ST_DRAIN: begin
                    bus.stage_wren   = ~hold_c;
                    // First PIPE cycle discards stale R contents; DRAIN blocks new fetches.
                    bus.stage_bubble = bubble_c
                                     | (fresh ? ~RW'(1) : RW'(0))
                                     | ((state == ST_DRAIN) ? RW'(1) : RW'(0));
                    bus.pc_wren      = (state == ST_PIPE) && !stall_c;
                    bus.ram_wren     = !(stall_c && (32'(bus.stall_stage) > MEM_STAGE));
                    bus.reg_wren     = !(stall_c && (32'(bus.stall_stage) == STAGES - 1));
                    bus.retire       = !(stall_c && (32'(bus.stall_stage) == STAGES - 1));
                    bus.flush_ack    = flush_c;
                end
                default: ;
            endcase
        end
    end

endmodule
